// File: rtl/led_chaser_pkg.sv
// Shared types and defaults for the LED chaser.
// Mode/direction enums plus default widths.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    ROT_L  = 2'b00,
    ROT_R  = 2'b01,
    BOUNCE = 2'b10,
    FREEZE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int WIDTH_DEF = 8;
  localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/led_chaser_prescaler.sv
// Step prescaler: one step_en pulse every step_div+1 enabled cycles.
// A clear (pattern load) resets the count and suppresses the step.
module led_chaser_prescaler
  import led_chaser_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] step_div,
  input  logic             clear,
  output logic             step_en
);

  logic [DIV_W-1:0] cnt;
  logic             hit;

  assign hit     = (cnt == step_div);
  assign step_en = enable & ~clear & hit;

  // cnt above a shrunk step_div rolls over at max and re-matches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (hit) cnt <= '0;
      else     cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED chaser top: rotate-left/right, bounce, freeze with load.
// Define LED_CHASER_BUTTON_SYNC_EN for a 2-flop button synchronizer.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             button,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             wrap
);

  logic btn_eff;

`ifdef LED_CHASER_BUTTON_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], button};
  end

  assign btn_eff = sync[1];
`else
  assign btn_eff = button;
`endif

  mode_t            mode_q;
  dir_t             dir_q;
  dir_t             dir_nx;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] led_nx;
  logic             wrap_q;
  logic             wrap_nx;
  logic             enable;
  logic             step;

  assign mode_q = mode_t'(mode);
  assign enable = btn_eff & (mode_q != FREEZE);

  led_chaser_prescaler #(
    .DIV_W (DIV_W)
  ) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .step_div (step_div),
    .clear    (load),
    .step_en  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= WIDTH'(1);
      dir_q  <= DIR_LEFT;
      wrap_q <= 1'b0;
    end else begin
      led_q  <= led_nx;
      dir_q  <= dir_nx;
      wrap_q <= wrap_nx;
    end
  end

  // step is already masked by load, so the arms are exclusive
  always_comb begin
    led_nx  = led_q;
    dir_nx  = dir_q;
    wrap_nx = 1'b0;
    unique case (1'b1)
      load: begin
        led_nx = load_pattern;
        dir_nx = DIR_LEFT;
      end
      step: begin
        unique case (mode_q)
          ROT_L: begin
            led_nx  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            wrap_nx = led_q[WIDTH-1];
          end
          ROT_R: begin
            led_nx  = {led_q[0], led_q[WIDTH-1:1]};
            wrap_nx = led_q[0];
          end
          BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q[WIDTH-1]) begin
                dir_nx  = DIR_RIGHT;
                led_nx  = led_q >> 1;
                wrap_nx = 1'b1;
              end else begin
                led_nx = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_nx  = DIR_LEFT;
                led_nx  = led_q << 1;
                wrap_nx = 1'b1;
              end else begin
                led_nx = led_q >> 1;
              end
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign led  = led_q;
  assign dir  = (dir_q == DIR_RIGHT);
  assign wrap = wrap_q;

endmodule
